// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Serialises two source-operand reads through a single-port
//               register file and hands the pair plus tag to the ALU stage.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int TAG_W   = 8,
    parameter int RF_LAT  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_src_a,
    input  logic [ADDR_W-1:0] i_src_b,
    input  logic [TAG_W-1:0]  i_tag,
    output logic [ADDR_W-1:0] o_rf_addr,
    output logic              o_rf_rw,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic              o_op_valid,
    input  logic              i_op_ready,
    output logic [DATA_W-1:0] o_op_a,
    output logic [DATA_W-1:0] o_op_b,
    output logic [TAG_W-1:0]  o_op_tag
);

    localparam int               c_CNT_W    = (RF_LAT > 0) ? $clog2(RF_LAT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RF_LAT);
    localparam logic             c_ZERO_R0  = (ZERO_R0 != 0);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_FETCH_A = 2'd1;
    localparam logic [1:0] c_FETCH_B = 2'd2;
    localparam logic [1:0] c_OUT     = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_src_a;
    logic [ADDR_W-1:0]  r_src_b;
    logic [TAG_W-1:0]   r_tag;
    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;

    logic w_accept;
    logic w_in_skip_a;
    logic w_in_zero_b;
    logic w_in_skip_b;
    logic w_lat_zero_b;
    logic w_lat_copy_b;
    logic w_fetching;
    logic w_last;

    assign w_accept     = i_req_valid && (r_state == c_IDLE);
    assign w_in_skip_a  = c_ZERO_R0 && (i_src_a == '0);
    assign w_in_zero_b  = c_ZERO_R0 && (i_src_b == '0);
    assign w_in_skip_b  = w_in_zero_b || (!w_in_skip_a && (i_src_b == i_src_a));
    // Only meaningful in FETCH_A, where A is known not to be skipped.
    assign w_lat_zero_b = c_ZERO_R0 && (r_src_b == '0);
    assign w_lat_copy_b = !w_lat_zero_b && (r_src_b == r_src_a);
    assign w_fetching   = (r_state == c_FETCH_A) || (r_state == c_FETCH_B);
    assign w_last       = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_req_valid) begin
                    if (!w_in_skip_a)      w_state_nxt = c_FETCH_A;
                    else if (!w_in_skip_b) w_state_nxt = c_FETCH_B;
                    else                   w_state_nxt = c_OUT;
                end
            end
            c_FETCH_A: begin
                if (w_last) w_state_nxt = (w_lat_zero_b || w_lat_copy_b) ? c_OUT : c_FETCH_B;
            end
            c_FETCH_B: begin
                if (w_last) w_state_nxt = c_OUT;
            end
            default: begin
                if (i_op_ready) w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_src_a <= '0;
            r_src_b <= '0;
            r_tag   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_fetching && !w_last) ? r_cnt + 1'b1 : '0;

            if (w_accept) begin
                r_src_a <= i_src_a;
                r_src_b <= i_src_b;
                r_tag   <= i_tag;
                if (w_in_skip_a) r_op_a <= '0;
                if (w_in_zero_b) r_op_b <= '0;
            end

            // Capture on the final cycle of each read window.
            if (r_state == c_FETCH_A && w_last) begin
                r_op_a <= i_rf_data;
                if (w_lat_copy_b) r_op_b <= i_rf_data;
            end
            if (r_state == c_FETCH_B && w_last) begin
                r_op_b <= i_rf_data;
            end
        end
    end

    always_comb begin
        o_rf_addr = '0;
        if (r_state == c_FETCH_A)      o_rf_addr = r_src_a;
        else if (r_state == c_FETCH_B) o_rf_addr = r_src_b;
    end

    assign o_rf_rw     = 1'b0;
    assign o_req_ready = (r_state == c_IDLE);
    assign o_op_valid  = (r_state == c_OUT);
    assign o_op_a      = r_op_a;
    assign o_op_b      = r_op_b;
    assign o_op_tag    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed self-checking bench for operand_fetch with a
//               one-cycle-latency register file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [7:0]  tag;
    logic [3:0]  rf_addr;
    logic        rf_rw;
    logic [15:0] rf_data;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [7:0]  op_tag;

    logic [15:0] rf_mem [16];

    int n_cmp = 0;
    int n_err = 0;

    operand_fetch #(
        .DATA_W (16),
        .ADDR_W (4),
        .TAG_W  (8),
        .RF_LAT (1),
        .ZERO_R0(1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_src_a    (src_a),
        .i_src_b    (src_b),
        .i_tag      (tag),
        .o_rf_addr  (rf_addr),
        .o_rf_rw    (rf_rw),
        .i_rf_data  (rf_data),
        .o_op_valid (op_valid),
        .i_op_ready (op_ready),
        .o_op_a     (op_a),
        .o_op_b     (op_b),
        .o_op_tag   (op_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file with one cycle of read latency.
    always @(posedge clk) rf_data <= rf_mem[rf_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called just after a rising edge with the FSM idle; returns at the
    // falling edge of the first cycle with o_op_valid high.
    task automatic run_req(input logic [3:0] a, input logic [3:0] b, input logic [7:0] t,
                           input logic [15:0] ea, input logic [15:0] eb,
                           input int elat, input logic [15:0] eseq);
        int k;
        bit found;
        src_a     = a;
        src_b     = b;
        tag       = t;
        req_valid = 1'b1;
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        src_a = 4'hF;
        src_b = 4'hF;
        tag   = 8'hFF;
        k     = 1;
        found = 1'b0;
        while (k <= 20 && !found) begin
            @(negedge clk);
            if (op_valid) found = 1'b1;
            else begin
                if (k <= 4) check("rf_addr", {28'd0, rf_addr}, {28'd0, eseq[4*(k-1) +: 4]});
                k++;
            end
        end
        check("latency", k, elat);
        check("addr_in_out", {28'd0, rf_addr}, 32'd0);
        check("rf_rw", {31'd0, rf_rw}, 32'd0);
        check("op_a", {16'd0, op_a}, {16'd0, ea});
        check("op_b", {16'd0, op_b}, {16'd0, eb});
        check("op_tag", {24'd0, op_tag}, {24'd0, t});
    endtask

    initial begin
        int seen_valid;
        foreach (rf_mem[i]) rf_mem[i] = 16'h1000 + 16'(i);
        rf_mem[0] = 16'hDEAD;
        rf_mem[3] = 16'h1234;
        rf_mem[5] = 16'hBEEF;
        rf_mem[7] = 16'h00FF;
        rf_mem[9] = 16'hA5A5;

        rst = 1'b1; req_valid = 1'b0; op_ready = 1'b1;
        src_a = 4'd0; src_b = 4'd0; tag = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_op_valid", {31'd0, op_valid}, 32'd0);
        check("rst_op_a", {16'd0, op_a}, 32'd0);
        check("rst_op_b", {16'd0, op_b}, 32'd0);
        check("rst_op_tag", {24'd0, op_tag}, 32'd0);
        check("rst_rf_addr", {28'd0, rf_addr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: two full reads
        run_req(4'd3, 4'd5, 8'h42, 16'h1234, 16'hBEEF, 5, 16'h5533);
        @(posedge clk); #1;
        check("handoff_valid_drop", {31'd0, op_valid}, 32'd0);

        // 2: A is r0, only B read
        run_req(4'd0, 4'd7, 8'h17, 16'h0000, 16'h00FF, 3, 16'h0077);
        @(posedge clk); #1;

        // 3: same source, single read
        run_req(4'd9, 4'd9, 8'h99, 16'hA5A5, 16'hA5A5, 3, 16'h0099);
        @(posedge clk); #1;

        // 4: both r0, then backpressure with a competing request
        op_ready = 1'b0;
        run_req(4'd0, 4'd0, 8'h44, 16'h0000, 16'h0000, 1, 16'h0000);
        src_a = 4'd3; src_b = 4'd5; tag = 8'hC3; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", {31'd0, op_valid}, 32'd1);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            check("bp_tag", {24'd0, op_tag}, 32'h44);
            check("bp_ab", {op_a, op_b}, 32'd0);
        end
        req_valid = 1'b0;
        op_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", {31'd0, op_valid}, 32'd0);
        check("bp_release_ready", {31'd0, req_ready}, 32'd1);
        check("bp_not_accepted_tag", {24'd0, op_tag}, 32'h44);
        @(posedge clk); #1;

        // 5: reset during FETCH_B
        src_a = 4'd3; src_b = 4'd5; tag = 8'h42; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_addr_b", {28'd0, rf_addr}, 32'd5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_valid", {31'd0, op_valid}, 32'd0);
        check("rst_mid_ab", {op_a, op_b}, 32'd0);
        check("rst_mid_addr", {28'd0, rf_addr}, 32'd0);
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (op_valid) seen_valid++;
        end
        check("rst_no_stale_valid", seen_valid, 0);
        @(posedge clk); #1;

        // 6: back-to-back, request held valid continuously
        src_a = 4'd3; src_b = 4'd5; tag = 8'h01; req_valid = 1'b1;
        @(posedge clk);
        #1 src_a = 4'd5; src_b = 4'd3; tag = 8'h02;
        begin
            int k;
            k = 1;
            while (k <= 20) begin
                @(negedge clk);
                if (op_valid) break;
                k++;
            end
            check("b2b_first_latency", k, 5);
            check("b2b_first_ab", {op_a, op_b}, 32'h1234BEEF);
            check("b2b_first_tag", {24'd0, op_tag}, 32'h01);
        end
        @(posedge clk); #1;
        run_req(4'd5, 4'd3, 8'h02, 16'hBEEF, 16'h1234, 5, 16'h3355);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
